// File: rtl/seq_shifter_if.sv
// Start/busy/done handshake bundle for the multi-cycle shifter.
// The master side issues requests and the slave side returns results.
interface seq_shifter_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, in, op, amt,
    input  out, busy, done, err
  );

  modport slave (
    input  start, in, op, amt,
    output out, busy, done, err
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle 16-bit shifter/rotator: one single-bit step per clock, amt steps per request.
// Illegal opcodes finish immediately with err set and the operand passed through.
//
// state | meaning
// IDLE  | waiting for start; out/err hold the last result
// SHIFT | applying one bit step per cycle until count reaches 1
// DONE  | done pulse; out/err valid; return to IDLE
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input logic        clk,
  input logic        rst,
  seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;

  state_t           state;
  logic [WIDTH-1:0] out_q;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] count;
  logic             err_q;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic [2:0] o);
    logic [WIDTH-1:0] r;
    r = v;
    case (o)
      OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[WIDTH-1:1]};
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out_q <= '0;
      op_q  <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // start is only honoured here, so requests during SHIFT/DONE are dropped
          if (bus.start) begin
            out_q <= bus.in;
            op_q  <= bus.op;
            count <= bus.amt;
            if (bus.op > OP_SRL) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              err_q <= 1'b0;
              state <= (bus.amt == '0) ? DONE : SHIFT;
            end
          end
        end
        SHIFT: begin
          out_q <= step(out_q, op_q);
          count <= count - 1'b1;
          if (count == AMT_W'(1)) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.err  = err_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: latency, results, error flag, ignored starts and async reset.
module tb_seq_shifter;
  logic clk;
  logic rst;
  int   passed;
  int   total;

  seq_shifter_if #(.WIDTH(16), .AMT_W(4)) bus ();

  seq_shifter #(.WIDTH(16), .AMT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive a request in the cycle before edge 0; returns at edge 0 + #1 (cycle 1).
  task automatic launch(input logic [15:0] i, input logic [2:0] o, input logic [3:0] a);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in    = i;
    bus.op    = o;
    bus.amt   = a;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in    = ~i;
    bus.op    = o ^ 3'b001;
    bus.amt   = ~a;
  endtask

  task automatic wait_done(input int first, output int lat);
    lat = first;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] i, input logic [2:0] o,
                     input logic [3:0] a, input logic [15:0] exp_out,
                     input logic exp_err, input int exp_lat);
    int lat;
    launch(i, o, a);
    chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
    wait_done(1, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_out"}, 32'(bus.out), 32'(exp_out));
    chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    passed = 0;
    total  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in    = '0;
    bus.op    = '0;
    bus.amt   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run("rol4",   16'h8001, 3'b000, 4'd4,  16'h0018, 1'b0, 5);
    run("sra15",  16'h8000, 3'b011, 4'd15, 16'hFFFF, 1'b0, 16);
    run("srl15",  16'h8000, 3'b100, 4'd15, 16'h0001, 1'b0, 16);
    run("sll8",   16'h00FF, 3'b010, 4'd8,  16'hFF00, 1'b0, 9);
    run("ror1",   16'h0001, 3'b001, 4'd1,  16'h8000, 1'b0, 2);
    run("amt0",   16'hBEEF, 3'b001, 4'd0,  16'hBEEF, 1'b0, 1);
    run("sra_pos", 16'h4000, 3'b011, 4'd3, 16'h0800, 1'b0, 4);
    run("rol15",  16'h0001, 3'b000, 4'd15, 16'h8000, 1'b0, 16);
    run("ill101", 16'h1234, 3'b101, 4'd5,  16'h1234, 1'b1, 1);
    @(posedge clk);
    #1;
    chk("ill_err_held", 32'(bus.err), 32'd1);
    run("ill111", 16'hA5A5, 3'b111, 4'd0,  16'hA5A5, 1'b1, 1);
    run("err_clr", 16'h1234, 3'b000, 4'd2, 16'h48D0, 1'b0, 3);

    // second start during SHIFT must be dropped
    launch(16'h0001, 3'b010, 4'd6);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.in    = 16'hFFFF;
    bus.amt   = 4'd1;
    bus.op    = 3'b010;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(4, lat);
    chk("ignore_lat", 32'(lat), 32'd7);
    chk("ignore_out", 32'(bus.out), 32'h0040);
    @(posedge clk);
    #1;
    chk("ignore_idle", 32'(bus.busy), 32'd0);

    // async reset mid-operation
    launch(16'h1234, 3'b000, 4'd10);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out", 32'(bus.out), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
    chk("arst_no_done", 32'(seen), 32'd0);
    run("post_rst", 16'hF0F0, 3'b100, 4'd4, 16'h0F0F, 1'b0, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
